// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// The CPU pushes bytes into a circular FIFO. A baud-timed shifter drains it and
// serialises each byte LSB first, with one start bit and one stop bit.
// Ports:
//   CLK        system clock, all logic on posedge
//   RST        asynchronous reset, active-high (flushes FIFO, truncates frame)
//   WR_DATA    byte to enqueue
//   WR_STROBE  enqueue WR_DATA this cycle (dropped while FULL)
//   FULL       FIFO holds 2**DEPTH_LOG2 bytes (registered)
//   EMPTY      FIFO holds 0 bytes (registered)
//   COUNT      FIFO occupancy 0..2**DEPTH_LOG2 (registered)
//   BUSY       frame in progress (registered with the state)
//   TXD        serial line, idle high (registered)
module uart_tx_fifo #(
  parameter int unsigned CLOCK_FREQ = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_STROBE,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  BUSY,
  output logic                  TXD
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned BIT_CYCLES = (CLOCK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned CW         = DEPTH_LOG2 + 1;
  localparam int unsigned PW         = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [7:0]       mem_q [DEPTH];

  logic bit_done;
  logic pop;
  logic wr_en;

  // Last clock of the current line bit.
  assign bit_done = (baud_cnt_q == CNT_W'(BIT_CYCLES - 1));
  // Head is consumed when idle, or at the end of a stop bit for back-to-back frames.
  assign pop      = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  // FULL is the registered value, so a pop in the same cycle does not rescue the write.
  assign wr_en    = WR_STROBE && !full_q;

  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign COUNT = count_q;
  assign BUSY  = busy_q;
  assign TXD   = txd_q;

  // FIFO storage; contents need no reset since pointers and count are cleared.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_done) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifter, baud counter and line output.
  always_comb begin
    baud_cnt_d = baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          txd_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            // shift_q[0] is on the line now; the next bit is shift_q[1].
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at BIT_CYCLES=10.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_fifo;

  logic       CLK;
  logic       RST;
  logic [7:0] WR_DATA;
  logic       WR_STROBE;
  logic       FULL;
  logic       EMPTY;
  logic [4:0] COUNT;
  logic       BUSY;
  logic       TXD;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .CLOCK_FREQ(1000000),
    .BAUD      (100000),
    .DEPTH_LOG2(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_DATA  (WR_DATA),
    .WR_STROBE(WR_STROBE),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .BUSY     (BUSY),
    .TXD      (TXD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check one 8N1 frame cycle by cycle; called at start edge + off cycles.
  task automatic check_frame(input logic [7:0] b, input int off, input string tag);
    logic [7:0] bb;
    logic       e;
    int         i;
    bb = b;
    for (int t = off; t < 100; t++) begin
      i = t / 10;
      if (i == 0)      e = 1'b0;
      else if (i == 9) e = 1'b1;
      else             e = bb[i-1];
      chk($sformatf("%s byte=%02h t=%0d", tag, b, t), 32'(TXD), 32'(e));
      tick();
    end
  endtask

  // Wait (bounded) for a start bit; on return we are at start edge + 1.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (TXD !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("%s start seen", tag), 32'(TXD), 32'd0);
  endtask

  logic [7:0] wrap_bytes [20];

  initial begin
    RST       = 1'b0;
    WR_DATA   = 8'h00;
    WR_STROBE = 1'b0;

    // Reset state
    #2 RST = 1'b1;
    #1;
    chk("rst txd",   32'(TXD),   32'd1);
    chk("rst empty", 32'(EMPTY), 32'd1);
    chk("rst full",  32'(FULL),  32'd0);
    chk("rst count", 32'(COUNT), 32'd0);
    chk("rst busy",  32'(BUSY),  32'd0);
    repeat (3) tick();
    RST = 1'b0;
    repeat (2) tick();
    chk("idle txd",  32'(TXD),   32'd1);
    chk("idle busy", 32'(BUSY),  32'd0);

    // Single byte 0x55: written at edge N, start bit from N+1, BUSY low at N+101
    WR_DATA = 8'h55; WR_STROBE = 1'b1;
    tick();
    WR_STROBE = 1'b0;
    chk("t2 empty after write", 32'(EMPTY), 32'd0);
    chk("t2 count after write", 32'(COUNT), 32'd1);
    chk("t2 txd still idle",    32'(TXD),   32'd1);
    tick();
    chk("t2 empty after pop",   32'(EMPTY), 32'd1);
    chk("t2 busy",              32'(BUSY),  32'd1);
    check_frame(8'h55, 0, "t2");
    chk("t2 busy dropped",      32'(BUSY),  32'd0);
    chk("t2 txd idle",          32'(TXD),   32'd1);
    repeat (3) tick();

    // Back-to-back 0xA5, 0x3C: second start exactly 100 clk after first
    WR_DATA = 8'hA5; WR_STROBE = 1'b1;
    tick();
    WR_DATA = 8'h3C;
    tick();
    WR_STROBE = 1'b0;
    chk("t3 count write+pop", 32'(COUNT), 32'd1);
    check_frame(8'hA5, 0, "t3a");
    check_frame(8'h3C, 0, "t3b");
    chk("t3 busy dropped",    32'(BUSY),  32'd0);
    repeat (3) tick();

    // Fill past full while the line is busy with 0xFF
    WR_DATA = 8'hFF; WR_STROBE = 1'b1;
    tick();
    WR_STROBE = 1'b0;
    tick();
    chk("t4 prior start", 32'(TXD),   32'd0);
    chk("t4 prior count", 32'(COUNT), 32'd0);
    for (int k = 0; k < 17; k++) begin
      WR_DATA = 8'(k); WR_STROBE = 1'b1;
      tick();
      if (k == 15) begin
        chk("t4 full after 16",  32'(FULL),  32'd1);
        chk("t4 count after 16", 32'(COUNT), 32'd16);
      end
    end
    WR_STROBE = 1'b0;
    chk("t4 count after 17", 32'(COUNT), 32'd16);
    chk("t4 full after 17",  32'(FULL),  32'd1);
    repeat (82) tick();
    chk("t5 stop bit",      32'(TXD),   32'd1);
    chk("t5 full pre-pop",  32'(FULL),  32'd1);
    // Write coincides with pop while full: dropped
    WR_DATA = 8'hEE; WR_STROBE = 1'b1;
    tick();
    chk("t5 count on pop",  32'(COUNT), 32'd15);
    chk("t5 full on pop",   32'(FULL),  32'd0);
    chk("t5 start",         32'(TXD),   32'd0);
    WR_DATA = 8'h77;
    tick();
    WR_STROBE = 1'b0;
    chk("t5 count refill",  32'(COUNT), 32'd16);
    chk("t5 full refill",   32'(FULL),  32'd1);
    check_frame(8'h00, 1, "t4");
    for (int k = 1; k < 16; k++) begin
      check_frame(8'(k), 0, "t4");
    end
    check_frame(8'h77, 0, "t5");
    chk("t4 busy end",  32'(BUSY),  32'd0);
    chk("t4 empty end", 32'(EMPTY), 32'd1);
    repeat (3) tick();

    // Write and pop coincide at COUNT=3
    WR_DATA = 8'h11; WR_STROBE = 1'b1;
    tick();
    WR_DATA = 8'h22;
    tick();
    chk("t6 count 1", 32'(COUNT), 32'd1);
    WR_DATA = 8'h33;
    tick();
    WR_DATA = 8'h44;
    tick();
    WR_STROBE = 1'b0;
    chk("t6 count 3", 32'(COUNT), 32'd3);
    repeat (97) tick();
    chk("t6 count pre", 32'(COUNT), 32'd3);
    WR_DATA = 8'h5A; WR_STROBE = 1'b1;
    tick();
    WR_STROBE = 1'b0;
    chk("t6 count stays 3", 32'(COUNT), 32'd3);
    chk("t6 next start",    32'(TXD),   32'd0);
    check_frame(8'h22, 0, "t6");
    check_frame(8'h33, 0, "t6");
    check_frame(8'h44, 0, "t6");
    check_frame(8'h5A, 0, "t6");
    chk("t6 busy end", 32'(BUSY), 32'd0);
    repeat (3) tick();

    // 20 spaced writes with concurrent reception, forcing pointer wrap
    for (int k = 0; k < 20; k++) wrap_bytes[k] = 8'((k * 37 + 5) & 8'hFF);
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          WR_DATA = wrap_bytes[k]; WR_STROBE = 1'b1;
          tick();
          WR_STROBE = 1'b0;
          repeat (39) tick();
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          wait_start($sformatf("wrap%0d", k));
          check_frame(wrap_bytes[k], 0, $sformatf("wrap%0d", k));
        end
      end
    join
    chk("wrap empty", 32'(EMPTY), 32'd1);
    chk("wrap busy",  32'(BUSY),  32'd0);
    repeat (3) tick();

    // Reset mid-frame with bytes queued
    WR_DATA = 8'h81; WR_STROBE = 1'b1;
    tick();
    WR_DATA = 8'h42;
    tick();
    WR_DATA = 8'h43;
    tick();
    WR_STROBE = 1'b0;
    repeat (30) tick();
    chk("mid count", 32'(COUNT), 32'd2);
    chk("mid busy",  32'(BUSY),  32'd1);
    chk("mid txd",   32'(TXD),   32'd0);
    #2 RST = 1'b1;
    #1;
    chk("mid rst txd",   32'(TXD),   32'd1);
    chk("mid rst count", 32'(COUNT), 32'd0);
    chk("mid rst empty", 32'(EMPTY), 32'd1);
    chk("mid rst busy",  32'(BUSY),  32'd0);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("post rst idle %0d", k), 32'(TXD), 32'd1);
    end
    chk("post rst busy",  32'(BUSY),  32'd0);
    chk("post rst empty", 32'(EMPTY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
